// File: rtl/noc_path_if.sv
// noc_path_if: hop-report inputs and packed-path outputs of noc_path_capture.
// The master modport drives the router-side strobes and the slave modport is
// the capture block that produces the display-side signals.
interface noc_path_if;
    logic        pkt_start;
    logic        hop_valid;
    logic [3:0]  hop_node;
    logic        pkt_end;
    logic [31:0] path_data;
    logic        display_en;
    logic        busy;
    logic        overflow;
    logic        timeout_err;

    modport master (
        output pkt_start, hop_valid, hop_node, pkt_end,
        input  path_data, display_en, busy, overflow, timeout_err
    );

    modport slave (
        input  pkt_start, hop_valid, hop_node, pkt_end,
        output path_data, display_en, busy, overflow, timeout_err
    );
endinterface

// File: rtl/noc_path_capture.sv
// noc_path_capture: records the node IDs a packet visits and packs them, first
// hop in bits [3:0], into a 32-bit word for the 7-seg path display. Unused
// slots hold PAD_NIBBLE. A completed path is presented with display_en held
// high for HOLD_CYCLES clocks.
// Optional feature macro: NOC_PATH_HOPCNT_EN -- keeps only 7 hop slots and puts
// the final hop count (or 4'hF on overflow) in path_data[31:28].
module noc_path_capture #(
    parameter int unsigned HOLD_CYCLES    = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [3:0]  PAD_NIBBLE     = 4'hA
) (
    input  logic       clk,
    input  logic       rst,
    noc_path_if.slave  bus
);
    localparam int unsigned MAX_HOPS = 8;
`ifdef NOC_PATH_HOPCNT_EN
    localparam int unsigned SLOTS = MAX_HOPS - 1;
`else
    localparam int unsigned SLOTS = MAX_HOPS;
`endif
    localparam logic [3:0] SLOT_LIMIT = 4'(SLOTS);

    // Guard the counter widths against degenerate parameter values of 1.
    localparam int unsigned HW = (HOLD_CYCLES    > 1) ? $clog2(HOLD_CYCLES)    : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    localparam logic [31:0] PAD_WORD = {8{PAD_NIBBLE}};

    logic [1:0]    r_state;
    logic [31:0]   r_buf;
    logic [3:0]    r_cnt;
    logic          r_ovf;
    logic [TW-1:0] r_timer;
    logic [HW-1:0] r_hold;
    logic [31:0]   r_path;
    logic          r_disp;
    logic          r_busy;
    logic          r_tmo;

    logic          w_rec;
    logic [31:0]   w_base_buf;
    logic [3:0]    w_base_cnt;
    logic          w_base_ovf;
    logic [31:0]   w_buf_next;
    logic [3:0]    w_cnt_next;
    logic          w_ovf_next;
    logic [31:0]   w_path;

    // Next work-buffer contents: pkt_start restarts from a padded buffer and a
    // hop in the same cycle lands in slot 0 of that fresh buffer.
    always_comb begin
        w_rec      = bus.hop_valid && (bus.pkt_start || (r_state == S_COLLECT));
        w_base_buf = bus.pkt_start ? PAD_WORD : r_buf;
        w_base_cnt = bus.pkt_start ? 4'd0 : r_cnt;
        w_base_ovf = bus.pkt_start ? 1'b0 : r_ovf;
        w_buf_next = w_base_buf;
        w_cnt_next = w_base_cnt;
        w_ovf_next = w_base_ovf;
        if (w_rec) begin
            if (w_base_cnt < SLOT_LIMIT) begin
                w_buf_next[{w_base_cnt[2:0], 2'b00} +: 4] = bus.hop_node;
                w_cnt_next = w_base_cnt + 4'd1;
            end else begin
                w_ovf_next = 1'b1;
            end
        end
`ifdef NOC_PATH_HOPCNT_EN
        w_path = {(w_ovf_next ? 4'hF : w_cnt_next), w_buf_next[27:0]};
`else
        w_path = w_buf_next;
`endif
    end

    // Control FSM plus registered outputs; a restart takes priority over all
    // other events in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_buf   <= PAD_WORD;
            r_cnt   <= 4'd0;
            r_ovf   <= 1'b0;
            r_timer <= '0;
            r_hold  <= '0;
            r_path  <= PAD_WORD;
            r_disp  <= 1'b0;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_buf <= w_buf_next;
            r_cnt <= w_cnt_next;
            r_ovf <= w_ovf_next;
            if (bus.pkt_start) begin
                // Abandoning an unfinished path counts as an abort.
                r_tmo   <= (r_state == S_COLLECT);
                r_state <= S_COLLECT;
                r_busy  <= 1'b1;
                r_disp  <= 1'b0;
                r_timer <= '0;
            end else begin
                case (r_state)
                    S_COLLECT: begin
                        if (bus.pkt_end) begin
                            r_path  <= w_path;
                            r_disp  <= 1'b1;
                            r_hold  <= '0;
                            r_busy  <= 1'b0;
                            r_state <= S_HOLD;
                        end else if (bus.hop_valid) begin
                            r_timer <= '0;
                        end else if (r_timer == TO_LAST) begin
                            r_tmo   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (r_hold == HOLD_LAST) begin
                            r_disp  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.path_data   = r_path;
    assign bus.display_en  = r_disp;
    assign bus.busy        = r_busy;
    assign bus.overflow    = r_ovf;
    assign bus.timeout_err = r_tmo;
endmodule
